// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution controller: opcodes, flag bit
// positions, controller state encoding and the opcode legality check.
package alu_pkg;

    localparam int DW = 16;
    localparam int FW = 6;

    localparam logic [4:0] OP_INC = 5'b00001;
    localparam logic [4:0] OP_DEC = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SBB = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_SHL = 5'b10000;
    localparam logic [4:0] OP_SHR = 5'b10001;
    localparam logic [4:0] OP_SAL = 5'b10010;
    localparam logic [4:0] OP_SAR = 5'b10011;
    localparam logic [4:0] OP_ROL = 5'b10100;
    localparam logic [4:0] OP_ROR = 5'b10101;
    localparam logic [4:0] OP_RCL = 5'b10110;
    localparam logic [4:0] OP_RCR = 5'b10111;

    localparam int FLAG_C  = 5;
    localparam int FLAG_Z  = 4;
    localparam int FLAG_N  = 3;
    localparam int FLAG_V  = 2;
    localparam int FLAG_P  = 1;
    localparam int FLAG_AC = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        return op inside {OP_INC, OP_DEC, [OP_ADD:OP_SBB], [OP_AND:OP_NOT], [OP_SHL:OP_RCR]};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x 16-bit register file: three asynchronous read ports (A, B, debug)
// and one synchronous write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] ra_addr,
    output logic [DW-1:0]           ra_data,
    input  logic [$clog2(NREG)-1:0] rb_addr,
    output logic [DW-1:0]           rb_data,
    input  logic [$clog2(NREG)-1:0] rd_addr,
    output logic [DW-1:0]           rd_data,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [DW-1:0]           wd
);

    logic [DW-1:0] mem_q [NREG];

    // NOTE: the array is reset because software relies on registers reading 0
    // after reset; this forces flops rather than a RAM macro, which is fine at 8 entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign ra_data = mem_q[ra_addr];
    assign rb_data = mem_q[rb_addr];
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequences one register-based ALU instruction at a time through
// IDLE -> READ -> EXEC -> WB, owning the register file and the flags register.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [4:0]              instr_op,
    input  logic [$clog2(NREG)-1:0] instr_dst,
    input  logic [$clog2(NREG)-1:0] instr_src,
    input  logic                    instr_imm_en,
    input  logic [DW-1:0]           instr_imm,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [4:0]              alu_f,
    output logic                    alu_cin,
    input  logic [DW-1:0]           alu_result,
    input  logic [FW-1:0]           alu_status,
    output logic                    done,
    output logic                    err,
    output logic [FW-1:0]           flags,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DW-1:0]           dbg_data
);

    localparam int AW = $clog2(NREG);

    state_e          state_q,  state_d;
    logic [4:0]      op_q,     op_d;
    logic [AW-1:0]   dst_q,    dst_d;
    logic [AW-1:0]   src_q,    src_d;
    logic            imm_en_q, imm_en_d;
    logic [DW-1:0]   imm_q,    imm_d;
    logic [DW-1:0]   alu_a_q,  alu_a_d;
    logic [DW-1:0]   alu_b_q,  alu_b_d;
    logic [4:0]      alu_f_q,  alu_f_d;
    logic [DW-1:0]   result_q, result_d;
    logic [FW-1:0]   status_q, status_d;
    logic [FW-1:0]   flags_q,  flags_d;
    logic            done_q,   done_d;
    logic            err_q,    err_d;

    logic [DW-1:0]   rf_a;
    logic [DW-1:0]   rf_b;
    logic            wr_en;

    // Writeback happens on the edge that leaves WB; an illegal op is flagged by err_q.
    assign wr_en = (state_q == ST_WB) && !err_q;

    alu_regfile #(.NREG(NREG)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (dst_q),
        .ra_data (rf_a),
        .rb_addr (src_q),
        .rb_data (rf_b),
        .rd_addr (dbg_addr),
        .rd_data (dbg_data),
        .we      (wr_en),
        .wa      (dst_q),
        .wd      (result_q)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        src_d    = src_q;
        imm_en_d = imm_en_q;
        imm_d    = imm_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_f_d  = alu_f_q;
        result_d = result_q;
        status_d = status_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d     = instr_op;
                    dst_d    = instr_dst;
                    src_d    = instr_src;
                    imm_en_d = instr_imm_en;
                    imm_d    = instr_imm;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                alu_a_d = rf_a;
                alu_b_d = imm_en_q ? imm_q : rf_b;
                alu_f_d = op_q;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                status_d = alu_status;
                done_d   = 1'b1;
                err_d    = !is_legal_op(op_q);
                state_d  = ST_WB;
            end
            ST_WB: begin
                if (!err_q) begin
                    flags_d = status_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_f_q  <= '0;
            result_q <= '0;
            status_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            imm_en_q <= imm_en_d;
            imm_q    <= imm_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_f_q  <= alu_f_d;
            result_q <= result_d;
            status_q <= status_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_f       = alu_f_q;
    assign alu_cin     = flags_q[FLAG_C];
    assign done        = done_q;
    assign err         = err_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: a behavioural ALU drives the datapath
// inputs and a register/flags reference model predicts every writeback.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [2:0]  instr_dst;
    logic [2:0]  instr_src;
    logic        instr_imm_en;
    logic [15:0] instr_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic [5:0]  alu_status;
    logic        done;
    logic        err;
    logic [5:0]  flags;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] ref_regs [8];
    logic [5:0]  ref_flags;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.NREG(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_dst    (instr_dst),
        .instr_src    (instr_src),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .alu_cin      (alu_cin),
        .alu_result   (alu_result),
        .alu_status   (alu_status),
        .done         (done),
        .err          (err),
        .flags        (flags),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Behavioural ALU; returns {C,Z,N,V,P,AC, result}.
    function automatic logic [21:0] alu_model(input logic [4:0] f, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] r, bb;
        logic        c, v, ac, ci;
        c = 1'b0; v = 1'b0; ac = 1'b0; r = '0; s = '0;
        bb = (f == 5'b00001 || f == 5'b00011) ? 16'd1 : b;
        ci = (f == 5'b00101 || f == 5'b00111) ? cin : 1'b0;
        case (f)
            5'b00001, 5'b00100, 5'b00101: begin
                s  = {1'b0, a} + {1'b0, bb} + 17'(ci);
                r  = s[15:0];
                c  = s[16];
                ac = ({1'b0, a[3:0]} + {1'b0, bb[3:0]} + 5'(ci)) > 5'd15;
                v  = (a[15] == bb[15]) && (r[15] != a[15]);
            end
            5'b00011, 5'b00110, 5'b00111: begin
                s  = {1'b0, a} - {1'b0, bb} - 17'(ci);
                r  = s[15:0];
                c  = s[16];
                ac = {1'b0, a[3:0]} < ({1'b0, bb[3:0]} + 5'(ci));
                v  = (a[15] != bb[15]) && (r[15] != a[15]);
            end
            5'b01000: r = a & b;
            5'b01001: r = a | b;
            5'b01010: r = a ^ b;
            5'b01011: r = ~a;
            5'b10000, 5'b10010: begin r = {a[14:0], 1'b0};  c = a[15]; end
            5'b10001:           begin r = {1'b0, a[15:1]};  c = a[0];  end
            5'b10011:           begin r = {a[15], a[15:1]}; c = a[0];  end
            5'b10100:           begin r = {a[14:0], a[15]}; c = a[15]; end
            5'b10101:           begin r = {a[0], a[15:1]};  c = a[0];  end
            5'b10110:           begin r = {a[14:0], cin};   c = a[15]; end
            5'b10111:           begin r = {cin, a[15:1]};   c = a[0];  end
            default: return {6'h3F, a ^ b ^ 16'hDEAD};
        endcase
        return {c, (r == 16'h0000), r[15], v, ~^r, ac, r};
    endfunction

    function automatic logic legal_ref(input logic [4:0] op);
        return op inside {5'b00001, 5'b00011, [5'b00100:5'b00111],
                          [5'b01000:5'b01011], [5'b10000:5'b10111]};
    endfunction

    always_comb {alu_status, alu_result} = alu_model(alu_f, alu_a, alu_b, alu_cin);

    // One instruction through the full handshake, checked cycle by cycle.
    task automatic do_instr(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] src,
                            input logic ie, input logic [15:0] imm);
        logic [15:0] a_exp, b_exp, old_dst;
        logic [21:0] rs;
        logic        legal;
        a_exp   = ref_regs[dst];
        b_exp   = ie ? imm : ref_regs[src];
        old_dst = ref_regs[dst];
        rs      = alu_model(op, a_exp, b_exp, ref_flags[5]);
        legal   = legal_ref(op);
        @(negedge clk);
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", instr_ready); end
        instr_valid = 1'b1; instr_op = op; instr_dst = dst; instr_src = src;
        instr_imm_en = ie; instr_imm = imm; dbg_addr = dst;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0; instr_op = 5'($urandom); instr_imm = 16'($urandom); instr_src = 3'($urandom);
        vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL read_ready: got %b want 0", instr_ready); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL read_done: got %b want 0", done); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (alu_a !== a_exp) begin miscompares++; $display("FAIL exec_alu_a: got %h want %h", alu_a, a_exp); end
        vectors++; if (alu_b !== b_exp) begin miscompares++; $display("FAIL exec_alu_b: got %h want %h", alu_b, b_exp); end
        vectors++; if (alu_f !== op) begin miscompares++; $display("FAIL exec_alu_f: got %b want %b", alu_f, op); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL exec_done: got %b want 0", done); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wb_done: got %b want 1", done); end
        vectors++; if (err !== !legal) begin miscompares++; $display("FAIL wb_err: got %b want %b (op %b)", err, !legal, op); end
        vectors++; if (dbg_data !== old_dst) begin miscompares++; $display("FAIL wb_dbg_old: got %h want %h", dbg_data, old_dst); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL post_pulse: got done %b err %b want 0 0", done, err); end
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL post_ready: got %b want 1", instr_ready); end
        if (legal) begin
            ref_regs[dst] = rs[15:0];
            ref_flags     = rs[21:16];
        end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (dbg_data !== ref_regs[dst]) begin miscompares++; $display("FAIL wb_reg R%0d: got %h want %h", dst, dbg_data, ref_regs[dst]); end
        vectors++; if (flags !== ref_flags) begin miscompares++; $display("FAIL wb_flags: got %h want %h", flags, ref_flags); end
        vectors++; if (alu_cin !== ref_flags[5]) begin miscompares++; $display("FAIL alu_cin: got %b want %b", alu_cin, ref_flags[5]); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        ref_flags = '0;
        #1;
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
        vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_pulses: got done %b err %b want 0 0", done, err); end
        vectors++; if (flags !== 6'h00 || alu_cin !== 1'b0) begin miscompares++; $display("FAIL rst_flags: got %h cin %b want 00 0", flags, alu_cin); end
        vectors++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_f !== 5'h0) begin miscompares++; $display("FAIL rst_alu_ops: got %h %h %h want 0 0 0", alu_a, alu_b, alu_f); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL rst_reg R%0d: got %h want 0000", i, dbg_data); end
        end
    endtask

    task automatic test_plan_sequence;
        do_instr(5'b01001, 3'd0, 3'd0, 1'b1, 16'hFFFF);
        vectors++; if (dbg_data !== 16'hFFFF || flags !== 6'h0A) begin miscompares++; $display("FAIL or_r0: got %h/%h want FFFF/0A", dbg_data, flags); end
        do_instr(5'b00100, 3'd0, 3'd0, 1'b1, 16'h0001);
        vectors++; if (dbg_data !== 16'h0000 || flags !== 6'h33) begin miscompares++; $display("FAIL add_carry: got %h/%h want 0000/33", dbg_data, flags); end
        do_instr(5'b00101, 3'd1, 3'd0, 1'b1, 16'h0000);
        vectors++; if (dbg_data !== 16'h0001 || flags !== 6'h00) begin miscompares++; $display("FAIL adc_r1: got %h/%h want 0001/00", dbg_data, flags); end
        do_instr(5'b01000, 3'd2, 3'd0, 1'b1, 16'h0000);
        do_instr(5'b01001, 3'd2, 3'd0, 1'b1, 16'h7FFF);
        do_instr(5'b00100, 3'd2, 3'd0, 1'b1, 16'h0001);
        vectors++; if (dbg_data !== 16'h8000 || flags !== 6'h0D) begin miscompares++; $display("FAIL add_ovf: got %h/%h want 8000/0D", dbg_data, flags); end
        do_instr(5'b01000, 3'd3, 3'd0, 1'b1, 16'h0000);
        do_instr(5'b01001, 3'd3, 3'd0, 1'b1, 16'h1234);
        do_instr(5'b00000, 3'd3, 3'd2, 1'b0, 16'h5555);
        vectors++; if (dbg_data !== 16'h1234 || flags !== 6'h00) begin miscompares++; $display("FAIL illegal_nowrite: got %h/%h want 1234/00", dbg_data, flags); end
        // Register-sourced B with dst == src: both operands see the pre-write value.
        do_instr(5'b00100, 3'd3, 3'd3, 1'b0, 16'h0000);
        vectors++; if (dbg_data !== 16'h2468) begin miscompares++; $display("FAIL dst_eq_src: got %h want 2468", dbg_data); end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  legal_list [18] = '{5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                         5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10000, 5'b10001,
                                         5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};
        logic [4:0]  ops  [10];
        logic [2:0]  dsts [10];
        logic [15:0] imms [10];
        logic [15:0] ea   [10];
        logic [21:0] er   [10];
        logic        exp_ready, exp_done;
        for (int i = 0; i < 10; i++) begin
            do ops[i] = legal_list[$urandom_range(0, 17)];
            while (i > 0 && ops[i] == ops[i-1]);
            dsts[i] = 3'($urandom);
            imms[i] = 16'($urandom);
        end
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            exp_ready = (i % 4 == 0);
            exp_done  = (i == 3 || i == 7 || i == 11);
            vectors++; if (instr_ready !== exp_ready) begin miscompares++; $display("FAIL b2b_ready c%0d: got %b want %b", i, instr_ready, exp_ready); end
            vectors++; if (done !== exp_done || err !== 1'b0) begin miscompares++; $display("FAIL b2b_done c%0d: got %b err %b want %b 0", i, done, err, exp_done); end
            if (i == 2 || i == 6 || i == 10) begin
                vectors++; if (alu_f !== ops[i-2] || alu_a !== ea[i-2] || alu_b !== imms[i-2]) begin
                    miscompares++; $display("FAIL b2b_operands c%0d: got %b %h %h want %b %h %h", i, alu_f, alu_a, alu_b, ops[i-2], ea[i-2], imms[i-2]);
                end
            end
            if (exp_done) begin
                ref_regs[dsts[i-3]] = er[i-3][15:0];
                ref_flags           = er[i-3][21:16];
            end
            if (i < 10 && i % 4 == 0) begin
                ea[i] = ref_regs[dsts[i]];
                er[i] = alu_model(ops[i], ea[i], imms[i], ref_flags[5]);
            end
            instr_valid  = (i < 10);
            instr_imm_en = 1'b1;
            instr_src    = 3'($urandom);
            if (i < 10) begin
                instr_op = ops[i]; instr_dst = dsts[i]; instr_imm = imms[i];
            end
            @(posedge clk);
        end
        @(negedge clk);
        vectors++; if (flags !== ref_flags) begin miscompares++; $display("FAIL b2b_flags: got %h want %h", flags, ref_flags); end
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            vectors++; if (dbg_data !== ref_regs[r]) begin miscompares++; $display("FAIL b2b_reg R%0d: got %h want %h", r, dbg_data, ref_regs[r]); end
        end
    endtask

    task automatic test_reset_mid;
        do_instr(5'b01001, 3'd4, 3'd0, 1'b1, 16'h00F0);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 5'b00100; instr_dst = 3'd4; instr_imm_en = 1'b1; instr_imm = 16'd5;
        dbg_addr = 3'd4;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        ref_flags = '0;
        #1;
        vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 1", instr_ready); end
        vectors++; if (dbg_data !== 16'h0 || flags !== 6'h0) begin miscompares++; $display("FAIL mid_rst_async: got %h/%h want 0000/00", dbg_data, flags); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (done !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1) begin
                miscompares++; $display("FAIL mid_rst_quiet c%0d: got done %b err %b ready %b want 0 0 1", i, done, err, instr_ready);
            end
        end
        vectors++; if (dbg_data !== 16'h0 || flags !== 6'h0) begin miscompares++; $display("FAIL mid_rst_state: got %h/%h want 0000/00", dbg_data, flags); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            do_instr(5'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_dst = '0; instr_src = '0;
        instr_imm_en = 1'b0; instr_imm = '0; dbg_addr = '0;
        test_reset();
        test_plan_sequence();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
